word_scroller: RTL and testbench

Upstream feeder for the 4-digit seven-segment scan stage. It generates the scan clock `segclk` from the system clock and accepts 5-letter words from game logic through a valid/ready handshake. Each word is committed only on a scan-frame boundary to avoid tearing. It presents four active-low digit patterns, optionally scrolling the word through an 8-slot ring so all five letters are visible on four digits.

---
 rtl/word_scroller.sv | 199 +++++++++++++++++++
 tb/tb_word_scroller.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/word_scroller.sv
// word_scroller: scan-clock divider plus 5-letter word buffer for a 4-digit
// seven-segment display. Words arrive through a valid/ready handshake, are
// committed only on a scan-frame boundary, and are shown through a 4-digit
// window over an 8-slot ring that can scroll.
module word_scroller #(
    parameter int SEG_DIV_BITS = 18,
    parameter int SCROLL_DIV   = 50_000_000
) (
    input  logic        clk,
    input  logic        clr_n,
    input  logic        load_valid,
    output logic        load_ready,
    input  logic [24:0] word_in,
    input  logic        scroll_en,
    output logic        segclk,
    output logic [27:0] digits
);

    localparam int CNT_W = SEG_DIV_BITS + 2;
    localparam int SC_W  = (SCROLL_DIV > 2) ? $clog2(SCROLL_DIV) : 1;
    localparam logic [SC_W-1:0] SC_LAST = SC_W'(SCROLL_DIV - 1);

    typedef enum logic {
        ST_EMPTY   = 1'b0,
        ST_PENDING = 1'b1
    } load_state_t;

    // Active-low {g,f,e,d,c,b,a} font; unused codes render blank.
    function automatic logic [6:0] font(input logic [4:0] code);
        logic [6:0] pat;
        case (code)
            5'd1:    pat = 7'b0001000; // A
            5'd2:    pat = 7'b0000011; // b
            5'd3:    pat = 7'b1000110; // C
            5'd4:    pat = 7'b0100001; // d
            5'd5:    pat = 7'b0000110; // E
            5'd6:    pat = 7'b0001110; // F
            5'd7:    pat = 7'b1000010; // G
            5'd8:    pat = 7'b0001001; // H
            5'd9:    pat = 7'b1111001; // I
            5'd10:   pat = 7'b1100001; // J
            5'd11:   pat = 7'b0001010; // K
            5'd12:   pat = 7'b1000111; // L
            5'd13:   pat = 7'b1101010; // M
            5'd14:   pat = 7'b1001000; // N
            5'd15:   pat = 7'b1000000; // O
            5'd16:   pat = 7'b0001100; // P
            5'd17:   pat = 7'b0011000; // q
            5'd18:   pat = 7'b1001100; // R
            5'd19:   pat = 7'b0010010; // S
            5'd20:   pat = 7'b0000111; // t
            5'd21:   pat = 7'b1000001; // U
            5'd22:   pat = 7'b1100011; // V
            5'd23:   pat = 7'b1010101; // W
            5'd24:   pat = 7'b0110110; // X
            5'd25:   pat = 7'b0010001; // Y
            5'd26:   pat = 7'b0100100; // Z
            default: pat = 7'b1111111; // blank (0 and 27..31)
        endcase
        return pat;
    endfunction

    logic [CNT_W-1:0] cnt_r;
    logic             segclk_r;
    load_state_t      state_r;
    load_state_t      state_next_s;
    logic             ready_r;
    logic [24:0]      pend_r;
    logic [24:0]      active_r;
    logic [2:0]       pos_r;
    logic [SC_W-1:0]  sc_r;
    logic [27:0]      digits_r;
    logic [27:0]      digits_next_s;
    logic [4:0]       ring_s [8];
    logic [2:0]       idx_s;
    logic             frame_end_s;
    logic             commit_s;
    logic             take_s;
    logic             sc_tc_s;

    // Event decode: frame boundary, commit, handshake transfer, scroll terminal count.
    always_comb begin
        frame_end_s = &cnt_r;
        commit_s    = frame_end_s && (state_r == ST_PENDING);
        take_s      = load_valid && (state_r == ST_EMPTY);
        sc_tc_s     = scroll_en && (sc_r == SC_LAST);
    end

    // Free-running frame counter and registered scan clock.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            cnt_r    <= {CNT_W{1'b0}};
            segclk_r <= 1'b0;
        end else begin
            cnt_r    <= cnt_r + CNT_W'(1);
            segclk_r <= cnt_r[SEG_DIV_BITS-1];
        end
    end

    // Load handshake next state: a word waits in PENDING until a frame boundary.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_EMPTY: begin
                if (take_s) begin
                    state_next_s = ST_PENDING;
                end else begin
                    state_next_s = ST_EMPTY;
                end
            end
            ST_PENDING: begin
                if (commit_s) begin
                    state_next_s = ST_EMPTY;
                end else begin
                    state_next_s = ST_PENDING;
                end
            end
            default: state_next_s = ST_EMPTY;
        endcase
    end

    // Handshake state register with registered ready flag.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_r <= ST_EMPTY;
            ready_r <= 1'b1;
        end else begin
            state_r <= state_next_s;
            ready_r <= (state_next_s == ST_EMPTY);
        end
    end

    // Pending word capture on a handshake transfer.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            pend_r <= 25'd0;
        end else if (take_s) begin
            pend_r <= word_in;
        end else begin
            pend_r <= pend_r;
        end
    end

    // Active word, window position and scroll counter; a commit overrides a scroll step.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            active_r <= 25'd0;
            pos_r    <= 3'd0;
            sc_r     <= {SC_W{1'b0}};
        end else if (commit_s) begin
            active_r <= pend_r;
            pos_r    <= 3'd0;
            sc_r     <= {SC_W{1'b0}};
        end else if (scroll_en) begin
            if (sc_tc_s) begin
                pos_r <= pos_r + 3'd1;
                sc_r  <= {SC_W{1'b0}};
            end else begin
                sc_r  <= sc_r + SC_W'(1);
            end
        end else begin
            sc_r <= sc_r;
        end
    end

    // Ring layout: five letters followed by three blank slots.
    always_comb begin
        for (int i = 0; i < 5; i++) begin
            ring_s[i] = active_r[5*i +: 5];
        end
        for (int i = 5; i < 8; i++) begin
            ring_s[i] = 5'd0;
        end
    end

    // Window decode: slot pos+k (mod 8) drives digit k, leftmost in the top bits.
    always_comb begin
        digits_next_s = {28{1'b1}};
        idx_s         = pos_r;
        for (int k = 0; k < 4; k++) begin
            idx_s = pos_r + 3'(k);
            digits_next_s[27-7*k -: 7] = font(ring_s[idx_s]);
        end
    end

    // Registered digit patterns.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            digits_r <= {28{1'b1}};
        end else begin
            digits_r <= digits_next_s;
        end
    end

    assign load_ready = ready_r;
    assign segclk     = segclk_r;
    assign digits     = digits_r;

endmodule

// File: tb/tb_word_scroller.sv
// Self-checking bench for word_scroller: a cycle-level behavioural model is
// compared on every falling edge, with hand-computed literal checkpoints.
module tb_word_scroller;

    localparam int SDB   = 2;
    localparam int SCD   = 10;
    localparam int FRAME = 1 << (SDB + 2);

    localparam logic [6:0] P_BL = 7'b1111111;
    localparam logic [6:0] P_A  = 7'b0001000;
    localparam logic [6:0] P_E  = 7'b0000110;
    localparam logic [6:0] P_N  = 7'b1001000;
    localparam logic [6:0] P_P  = 7'b0001100;
    localparam logic [6:0] P_R  = 7'b1001100;

    logic        clk        = 1'b0;
    logic        clr_n      = 1'b0;
    logic        load_valid = 1'b0;
    logic        scroll_en  = 1'b0;
    logic [24:0] word_in    = 25'd0;
    logic        load_ready;
    logic        segclk;
    logic [27:0] digits;

    word_scroller #(.SEG_DIV_BITS(SDB), .SCROLL_DIV(SCD)) dut (
        .clk        (clk),
        .clr_n      (clr_n),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .word_in    (word_in),
        .scroll_en  (scroll_en),
        .segclk     (segclk),
        .digits     (digits)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;
    int cyc    = 0;

    // ---------------- behavioural model ----------------
    int         m_cnt, m_sc, m_pos;
    bit         m_seg, m_pend_v;
    logic [4:0] m_act  [5];
    logic [4:0] m_pend [5];
    logic [27:0] m_dig;

    function automatic logic [6:0] mfont(input int c);
        case (c)
            0, 27, 28, 29, 30, 31: return P_BL;
            1:  return P_A;
            5:  return P_E;
            14: return P_N;
            16: return P_P;
            18: return P_R;
            default: return 7'bxxxxxxx;
        endcase
    endfunction

    function automatic logic [27:0] mwindow(input logic [4:0] a [5], input int pos);
        int ring [8];
        for (int i = 0; i < 8; i++) ring[i] = (i < 5) ? int'(a[i]) : 0;
        return {mfont(ring[pos % 8]), mfont(ring[(pos + 1) % 8]),
                mfont(ring[(pos + 2) % 8]), mfont(ring[(pos + 3) % 8])};
    endfunction

    always @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            m_cnt    <= 0;
            m_seg    <= 1'b0;
            m_pend_v <= 1'b0;
            m_pos    <= 0;
            m_sc     <= 0;
            m_dig    <= 28'hFFFFFFF;
            for (int i = 0; i < 5; i++) begin
                m_act[i]  <= 5'd0;
                m_pend[i] <= 5'd0;
            end
        end else begin
            m_cnt <= (m_cnt + 1) % FRAME;
            m_seg <= ((m_cnt >> (SDB - 1)) % 2) == 1;
            m_dig <= mwindow(m_act, m_pos);
            if (m_cnt == FRAME - 1 && m_pend_v) begin
                for (int i = 0; i < 5; i++) m_act[i] <= m_pend[i];
                m_pend_v <= 1'b0;
                m_pos    <= 0;
                m_sc     <= 0;
            end else begin
                if (scroll_en) begin
                    if (m_sc == SCD - 1) begin
                        m_sc  <= 0;
                        m_pos <= (m_pos + 1) % 8;
                    end else begin
                        m_sc <= m_sc + 1;
                    end
                end
                if (load_valid && !m_pend_v) begin
                    m_pend_v <= 1'b1;
                    for (int i = 0; i < 5; i++) m_pend[i] <= word_in[5*i +: 5];
                end
            end
        end
    end

    // ---------------- comparison helpers ----------------
    task automatic cmp(input string name, input logic [27:0] act, input logic [27:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp("model_digits", digits, m_dig);
            cmp("model_load_ready", {27'd0, load_ready}, {27'd0, !m_pend_v});
            cmp("model_segclk", {27'd0, segclk}, {27'd0, m_seg});
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    function automatic logic [24:0] word5(input int l0, input int l1, input int l2,
                                          input int l3, input int l4);
        return {5'(l4), 5'(l3), 5'(l2), 5'(l1), 5'(l0)};
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        int  rises;
        bit  prev_seg;
        rises    = 0;
        prev_seg = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        clr_n  = 1'b1;
        chk_en = 1'b1;
        cyc    = 0;

        cmp("reset_digits", digits, 28'hFFFFFFF);
        cmp("reset_ready", {27'd0, load_ready}, 28'd1);
        cmp("reset_segclk", {27'd0, segclk}, 28'd0);

        // Load/commit, backpressure, divider and scroll phases on one timeline.
        for (int c = 0; c < 212; c++) begin
            if (c < 64) begin
                if (segclk && !prev_seg) rises++;
                prev_seg = segclk;
            end
            case (c)
                3:   begin load_valid = 1'b1; word_in = word5(14, 5, 18, 16, 0); end
                4:   begin load_valid = 1'b0; word_in = 25'd0;
                           cmp("ready_low_c4", {27'd0, load_ready}, 28'd0); end
                5:   begin load_valid = 1'b1; word_in = word5(1, 16, 5, 14, 18); end
                6:   begin load_valid = 1'b0; word_in = 25'd0; end
                15:  cmp("ready_low_c15", {27'd0, load_ready}, 28'd0);
                16:  cmp("ready_high_c16", {27'd0, load_ready}, 28'd1);
                17:  cmp("nerp_c17", digits, {P_N, P_E, P_R, P_P});
                40:  cmp("backpressure_c40", digits, {P_N, P_E, P_R, P_P});
                64:  cmp("seg_rises_64", 28'(rises), 28'd16);
                67:  begin load_valid = 1'b1; word_in = word5(1, 16, 5, 14, 18); end
                68:  begin load_valid = 1'b0; word_in = 25'd0; end
                80:  scroll_en = 1'b1;
                85:  cmp("scroll_apen", digits, {P_A, P_P, P_E, P_N});
                95:  cmp("scroll_penr", digits, {P_P, P_E, P_N, P_R});
                105: cmp("scroll_enr_", digits, {P_E, P_N, P_R, P_BL});
                155: cmp("scroll__ape", digits, {P_BL, P_A, P_P, P_E});
                165: cmp("scroll_wrap_apen", digits, {P_A, P_P, P_E, P_N});
                167: scroll_en = 1'b0;
                200: cmp("scroll_frozen", digits, {P_A, P_P, P_E, P_N});
                209: begin load_valid = 1'b1; word_in = word5(14, 14, 14, 14, 14); end
                210: begin load_valid = 1'b0; word_in = 25'd0; end
                default: ;
            endcase
            tick();
        end

        // Asynchronous reset with a word pending.
        #2 clr_n = 1'b0;
        #1;
        cmp("midreset_digits", digits, 28'hFFFFFFF);
        cmp("midreset_ready", {27'd0, load_ready}, 28'd1);
        cmp("midreset_segclk", {27'd0, segclk}, 28'd0);
        @(posedge clk);
        @(negedge clk);
        clr_n = 1'b1;
        cyc   = 0;

        // Stale pending word must never appear; collision of commit and scroll step.
        for (int c = 0; c < 40; c++) begin
            case (c)
                2:  cmp("no_stale_c2", digits, 28'hFFFFFFF);
                3:  begin load_valid = 1'b1; word_in = word5(18, 1, 14, 5, 16); end
                4:  begin load_valid = 1'b0; word_in = 25'd0; end
                6:  scroll_en = 1'b1;
                16: cmp("no_stale_c16", digits, 28'hFFFFFFF);
                17: cmp("collision_rane", digits, {P_R, P_A, P_N, P_E});
                26: cmp("collision_hold", digits, {P_R, P_A, P_N, P_E});
                27: cmp("collision_step", digits, {P_A, P_N, P_E, P_P});
                default: ;
            endcase
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
